// File: rtl/decimal_adjust.sv
// Post-ALU decimal-correction stage: per-nibble BCD fix-up of an ADC/SBC result,
// N/Z recompute, V/C pass-through, buffered in a 2-entry skid FIFO gated by RDY.
module decimal_adjust #(
  parameter int dw = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          RDY,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          adc,
  input  logic          D,
  input  logic [dw-1:0] alu_out,
  input  logic          alu_co,
  input  logic          alu_hc,
  input  logic          alu_v,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [dw-1:0] OUT,
  output logic          CO,
  output logic          V,
  output logic          Z,
  output logic          N
);

  typedef struct packed {
    logic [dw-1:0] data;
    logic          co;
    logic          v;
    logic          z;
    logic          n;
  } entry_t;

  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } count_t;

  count_t count_q, count_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;

  logic          push;
  logic          pop;
  logic [3:0]    lo_adj;
  logic [3:0]    hi_adj;
  logic [3:0]    lo_offset;
  logic [3:0]    hi_offset;
  logic [dw-1:0] adjusted;
  entry_t        new_entry;

  assign in_ready  = (count_q != CNT_FULL);
  assign out_valid = (count_q != CNT_EMPTY);

  assign push = in_valid & in_ready & RDY;
  assign pop  = out_valid & out_ready & RDY;

  // Each nibble is corrected independently; 0xA acts as -6 modulo 16 and no
  // carry is allowed to ripple between nibbles or into bit 8.
  always_comb begin
    lo_offset = 4'h0;
    hi_offset = 4'h0;
    if (D && adc && alu_hc)
      lo_offset = 4'h6;
    else if (D && !adc && !alu_hc)
      lo_offset = 4'hA;
    if (D && adc && alu_co)
      hi_offset = 4'h6;
    else if (D && !adc && !alu_co)
      hi_offset = 4'hA;

    lo_adj = alu_out[3:0] + lo_offset;
    hi_adj = alu_out[7:4] + hi_offset;

    adjusted      = alu_out;
    adjusted[7:0] = {hi_adj, lo_adj};

    new_entry.data = adjusted;
    new_entry.co   = alu_co;
    new_entry.v    = alu_v;
    new_entry.z    = ~|adjusted;
    new_entry.n    = adjusted[dw-1];
  end

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (count_q)
      CNT_EMPTY: begin
        if (push) begin
          head_d  = new_entry;
          count_d = CNT_ONE;
        end
      end
      CNT_ONE: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (push) begin
          tail_d  = new_entry;
          count_d = CNT_FULL;
        end else if (pop) begin
          count_d = CNT_EMPTY;
        end
      end
      CNT_FULL: begin
        // in_ready is low here, so a pop can only promote the tail.
        if (pop) begin
          head_d  = tail_q;
          count_d = CNT_ONE;
        end
      end
      default: begin
        count_d = CNT_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= CNT_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign OUT = head_q.data;
  assign CO  = head_q.co;
  assign V   = head_q.v;
  assign Z   = head_q.z;
  assign N   = head_q.n;

endmodule

// File: tb/tb_decimal_adjust.sv
// Directed self-checking bench for decimal_adjust: BCD correction vectors,
// backpressure ordering, RDY stall and asynchronous reset with a full buffer.
module tb_decimal_adjust;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          RDY;
  logic          in_valid;
  logic          in_ready;
  logic          adc;
  logic          D;
  logic [DW-1:0] alu_out;
  logic          alu_co;
  logic          alu_hc;
  logic          alu_v;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] OUT;
  logic          CO;
  logic          V;
  logic          Z;
  logic          N;

  int checkCount = 0;
  int failCount  = 0;

  decimal_adjust #(.dw(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .RDY       (RDY),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .adc       (adc),
    .D         (D),
    .alu_out   (alu_out),
    .alu_co    (alu_co),
    .alu_hc    (alu_hc),
    .alu_v     (alu_v),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .OUT       (OUT),
    .CO        (CO),
    .V         (V),
    .Z         (Z),
    .N         (N)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkEntry(input string tag, input logic [DW-1:0] expOut,
                            input logic expCo, input logic expV,
                            input logic expZ, input logic expN);
    checkOutput({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    checkOutput({tag, ".out"},   {16'd0, OUT},       {16'd0, expOut});
    checkOutput({tag, ".co"},    {31'd0, CO},        {31'd0, expCo});
    checkOutput({tag, ".v"},     {31'd0, V},         {31'd0, expV});
    checkOutput({tag, ".z"},     {31'd0, Z},         {31'd0, expZ});
    checkOutput({tag, ".n"},     {31'd0, N},         {31'd0, expN});
  endtask

  task automatic applyStimulus(input logic a, input logic d, input logic [DW-1:0] val,
                               input logic co, input logic hc, input logic v);
    adc      = a;
    D        = d;
    alu_out  = val;
    alu_co   = co;
    alu_hc   = hc;
    alu_v    = v;
    in_valid = 1'b1;
  endtask

  // Push one vector on the next edge, then look at the head half a cycle later.
  task automatic pushAndCheck(input string tag, input logic a, input logic d,
                              input logic [DW-1:0] val, input logic co, input logic hc,
                              input logic v, input logic [DW-1:0] expOut,
                              input logic expZ, input logic expN);
    applyStimulus(a, d, val, co, hc, v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkEntry(tag, expOut, co, v, expZ, expN);
  endtask

  initial begin
    reset_n   = 1'b0;
    RDY       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    adc       = 1'b0;
    D         = 1'b0;
    alu_out   = '0;
    alu_co    = 1'b0;
    alu_hc    = 1'b0;
    alu_v     = 1'b0;

    #12;
    checkOutput("rst.valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst.ready", {31'd0, in_ready},  32'd1);
    checkOutput("rst.out",   {16'd0, OUT},       32'd0);
    checkOutput("rst.flags", {28'd0, CO, V, Z, N}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // BCD correction vectors; expected results worked out by hand.
    pushAndCheck("adc_1a", 1'b1, 1'b1, 16'h001A, 1'b0, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0);
    pushAndCheck("adc_99p01", 1'b1, 1'b1, 16'h00AA, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    pushAndCheck("adc_12aa", 1'b1, 1'b1, 16'h12AA, 1'b1, 1'b1, 1'b0, 16'h1200, 1'b0, 1'b0);
    pushAndCheck("sbc_10m01", 1'b0, 1'b1, 16'h000F, 1'b1, 1'b0, 1'b0, 16'h0009, 1'b0, 1'b0);
    pushAndCheck("sbc_bin", 1'b0, 1'b0, 16'h000F, 1'b1, 1'b0, 1'b0, 16'h000F, 1'b0, 1'b0);
    pushAndCheck("sbc_00m01", 1'b0, 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0, 16'h0099, 1'b0, 1'b0);
    pushAndCheck("adc_noadj", 1'b1, 1'b1, 16'h0045, 1'b0, 1'b0, 1'b0, 16'h0045, 1'b0, 1'b0);
    pushAndCheck("bin_neg_v", 1'b1, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    pushAndCheck("sbc_hi_neg", 1'b0, 1'b1, 16'hABF0, 1'b0, 1'b1, 1'b1, 16'hAB90, 1'b0, 1'b1);

    @(posedge clk);
    @(negedge clk);
    checkOutput("drain.valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: A and B fill the buffer, C waits.
    out_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    alu_out = 16'h2222;
    @(posedge clk);
    #1;
    alu_out = 16'h3333;
    @(negedge clk);
    checkOutput("bp.full_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("bp.head_a", {16'd0, OUT}, 32'h1111);
    @(negedge clk);
    checkOutput("bp.hold_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("bp.hold_a", {16'd0, OUT}, 32'h1111);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp.head_b", {16'd0, OUT}, 32'h2222);
    checkOutput("bp.ready_b", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp.head_c", {16'd0, OUT}, 32'h3333);
    checkOutput("bp.valid_c", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    checkOutput("bp.empty", {31'd0, out_valid}, 32'd0);

    // RDY stall: X buffered, Y presented, nothing moves for three cycles.
    applyStimulus(1'b1, 1'b0, 16'h4444, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    alu_out = 16'h5555;
    RDY     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rdy.out%0d", i), {16'd0, OUT}, 32'h4444);
      checkOutput($sformatf("rdy.valid%0d", i), {31'd0, out_valid}, 32'd1);
      checkOutput($sformatf("rdy.ready%0d", i), {31'd0, in_ready}, 32'd1);
    end
    RDY = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rdy.resume", {16'd0, OUT}, 32'h5555);
    @(negedge clk);
    checkOutput("rdy.empty", {31'd0, out_valid}, 32'd0);

    // Async reset with the buffer full.
    out_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'h8001, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    alu_out = 16'h0002;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkEntry("full", 16'h8001, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("full.ready", {31'd0, in_ready}, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst.valid", {31'd0, out_valid}, 32'd0);
    checkOutput("arst.out",   {16'd0, OUT},       32'd0);
    checkOutput("arst.flags", {28'd0, CO, V, Z, N}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("arst.ready", {31'd0, in_ready}, 32'd1);
    checkOutput("arst.empty", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
